// File: rtl/mdu_pkg.sv
// Shared types and helpers for the iterative RV64M multiply/divide unit.
// Operation encoding follows the RV funct3 order for the M extension.
package mdu_pkg;

    localparam int XLEN = 64;
    localparam int CW   = $clog2(XLEN);

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } mdu_state_e;

    function automatic logic is_signed_a(input mdu_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(input mdu_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_div(input mdu_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift {rem,quo} left by one, trial-subtract the
// divisor from the remainder, and shift in the resulting quotient bit.
module mdu_div_step
    import mdu_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // rem < divisor holds between steps, so a 65-bit trial difference never overflows
    assign shifted = {rem, quo[XLEN-1]};
    assign diff    = shifted - {1'b0, divisor};

    always_comb begin
        if (diff[XLEN]) begin
            rem_next = shifted[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end else begin
            rem_next = diff[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit: one bit per clock, one operation in flight,
// valid/ready request and response channels.
module mdu_iter
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic            req_word,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    mdu_state_e        state, state_nxt;
    logic [CW-1:0]     cnt;
    mdu_op_e           op_q;
    logic              word_q, neg_q, neg_r;
    logic [2*XLEN-1:0] mcand, prod;
    logic [XLEN-1:0]   mplier, divisor, rem, quo, rem_nxt, quo_nxt;

    mdu_op_e           op_in;
    logic              accept, sa, sb, b_zero, ovf;
    logic [XLEN-1:0]   a_abs, b_abs, a_sext;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, raw, result;

    assign op_in      = mdu_op_e'(req_op);
    assign req_ready  = (state == S_IDLE) && !flush;
    assign accept     = req_valid && req_ready;
    assign busy       = (state != S_IDLE);
    assign resp_valid = (state == S_DONE);

    // Operand conditioning: W ops work on the low 32 bits, magnitudes feed the datapath.
    always_comb begin
        sa = is_signed_a(op_in) && (req_word ? req_a[31] : req_a[XLEN-1]);
        sb = is_signed_b(op_in) && (req_word ? req_b[31] : req_b[XLEN-1]);
        if (req_word) begin
            a_sext = {{(XLEN-32){req_a[31]}}, req_a[31:0]};
            a_abs  = {{(XLEN-32){1'b0}}, (sa ? -req_a[31:0] : req_a[31:0])};
            b_abs  = {{(XLEN-32){1'b0}}, (sb ? -req_b[31:0] : req_b[31:0])};
            b_zero = (req_b[31:0] == 32'd0);
            ovf    = (req_a[31:0] == 32'h8000_0000) && (&req_b[31:0]);
        end else begin
            a_sext = req_a;
            a_abs  = sa ? -req_a : req_a;
            b_abs  = sb ? -req_b : req_b;
            b_zero = (req_b == '0);
            ovf    = (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (&req_b);
        end
        ovf = ovf && is_signed_a(op_in) && is_div(op_in);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: next state defaults to hold before the case, so no path can infer a latch.
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) begin
                if (!is_div(op_in))      state_nxt = S_MUL;
                else if (b_zero || ovf) state_nxt = S_FIX;
                else                    state_nxt = S_DIV;
            end
            S_MUL, S_DIV: if (cnt == '0) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_DONE;
            S_DONE: if (resp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    mdu_div_step u_div_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .rem_next (rem_nxt),
        .quo_next (quo_nxt)
    );

    // Sign correction and result selection used on the FIX edge.
    always_comb begin
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -quo  : quo;
        rem_fix  = neg_r ? -rem  : rem;
        case (op_q)
            OP_MUL:                      raw = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: raw = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             raw = quo_fix;
            default:                     raw = rem_fix;
        endcase
        result = word_q ? {{(XLEN-32){raw[31]}}, raw[31:0]} : raw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            op_q      <= OP_MUL;
            word_q    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            mcand     <= '0;
            prod      <= '0;
            mplier    <= '0;
            divisor   <= '0;
            rem       <= '0;
            quo       <= '0;
            resp_data <= '0;
        end else if (!flush) begin
            case (state)
                S_IDLE: if (accept) begin
                    op_q    <= op_in;
                    word_q  <= req_word;
                    cnt     <= req_word ? CW'(31) : CW'(XLEN-1);
                    mcand   <= {{XLEN{1'b0}}, a_abs};
                    mplier  <= b_abs;
                    prod    <= '0;
                    divisor <= b_abs;
                    // Special divides preload the final quotient/remainder and skip iteration.
                    if (is_div(op_in) && b_zero) begin
                        quo   <= '1;
                        rem   <= a_sext;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end else if (ovf) begin
                        quo   <= a_sext;
                        rem   <= '0;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end else begin
                        quo   <= req_word ? {a_abs[31:0], 32'd0} : a_abs;
                        rem   <= '0;
                        neg_q <= sa ^ sb;
                        neg_r <= sa;
                    end
                end
                S_MUL: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                S_DIV: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                S_FIX: resp_data <= result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: arithmetic reference model plus scoreboard,
// and directed vectors with hand-computed results and latencies.
module tb_mdu_iter;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic        req_word = 1'b0;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] resp_data;
    logic        busy;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    mdu_iter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_word   (req_word),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RV64M semantics in plain arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] xa, xb;
        logic [127:0]        p;
        longint              sa, sb;
        int                  x, y;
        int unsigned         ux, uy;
        logic [31:0]         r;
        logic [63:0]         res;
        sa = a; sb = b; x = a[31:0]; y = b[31:0]; ux = a[31:0]; uy = b[31:0];
        r = '0; res = '0;
        if (w) begin
            case (op)
                3'd0: r = x * y;
                3'd4: if (y == 0) r = 32'hFFFF_FFFF;
                      else if (a[31:0] == 32'h8000_0000 && y == -1) r = a[31:0];
                      else r = x / y;
                3'd5: if (uy == 0) r = 32'hFFFF_FFFF; else r = ux / uy;
                3'd6: if (y == 0) r = a[31:0];
                      else if (a[31:0] == 32'h8000_0000 && y == -1) r = 32'd0;
                      else r = x % y;
                3'd7: if (uy == 0) r = a[31:0]; else r = ux % uy;
                default: r = 32'd0;
            endcase
            res = {{32{r[31]}}, r};
        end else begin
            case (op)
                3'd0: res = a * b;
                3'd1: begin xa = sa; xb = sb; p = xa * xb; res = p[127:64]; end
                3'd2: begin xa = sa; xb = {64'd0, b}; p = xa * xb; res = p[127:64]; end
                3'd3: begin p = {64'd0, a} * {64'd0, b}; res = p[127:64]; end
                3'd4: if (b == 0) res = '1;
                      else if (a == 64'h8000_0000_0000_0000 && b == '1) res = a;
                      else res = sa / sb;
                3'd5: if (b == 0) res = '1; else res = a / b;
                3'd6: if (b == 0) res = a;
                      else if (a == 64'h8000_0000_0000_0000 && b == '1) res = '0;
                      else res = sa % sb;
                default: if (b == 0) res = a; else res = a % b;
            endcase
        end
        return res;
    endfunction

    // Scoreboard: sampled on the falling edge, handshakes take effect on the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() == 0) begin
                check("resp_valid_no_pending", {63'd0, resp_valid}, 64'd0);
            end else if (resp_valid) begin
                check("resp_data_model", resp_data, exp_q[0]);
                check("req_ready_while_resp", {63'd0, req_ready}, 64'd0);
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                if (resp_valid && resp_ready) void'(exp_q.pop_front());
                if (req_valid && req_ready) exp_q.push_back(model(req_op, req_word, req_a, req_b));
            end
        end
    end

    task automatic wait_resp(input string name, input int exp_edges, input logic [63:0] exp);
        int edges;
        edges = 1;
        @(negedge clk);
        while (!resp_valid && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        check({name, "_latency"}, 64'(edges), 64'(exp_edges));
        check({name, "_data"}, resp_data, exp);
    endtask

    task automatic run_op(input mdu_op_e op, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp,
                          input int exp_edges, input string name, input bit take);
        int guard;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_word = w; req_a = a; req_b = b;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check({name, "_accept_timeout"}, 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp(name, exp_edges, exp);
        if (take) begin
            @(negedge clk);
            check({name, "_idle_after"}, {63'd0, busy}, 64'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_resp_data", resp_data, 64'd0);
        check("reset_req_ready", {63'd0, req_ready}, 64'd1);
        #1 rst_n = 1'b1;

        run_op(OP_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 66, "mulhu", 1'b1);
        run_op(OP_DIV, 1'b0, -64'sd7, 64'd2, -64'sd3, 66, "div_neg", 1'b1);
        run_op(OP_REM, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, "rem_neg", 1'b1);
        run_op(OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66, "divu", 1'b1);
        run_op(OP_DIV, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, "div_by_zero", 1'b1);
        run_op(OP_REMU, 1'b0, 64'd5, 64'd0, 64'd5, 2, "remu_by_zero", 1'b1);
        run_op(OP_DIV, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 2, "div_ovf", 1'b1);
        run_op(OP_REM, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 2, "rem_ovf", 1'b1);
        run_op(OP_MUL, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34, "mulw", 1'b1);
        run_op(OP_DIV, 1'b1, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 2, "divw_ovf", 1'b1);
        run_op(OP_MUL, 1'b0, 64'h1_0000_0001, 64'h1_0000_0001, 64'h2_0000_0001, 66, "mul64", 1'b1);
        run_op(OP_MULH, 1'b0, -64'sd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 66, "mulh_neg", 1'b1);
        run_op(OP_MULHSU, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, "mulhsu", 1'b1);
        run_op(OP_REM, 1'b1, 64'hFFFF_FFF9, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 34, "remw", 1'b1);
        run_op(OP_DIVU, 1'b1, 64'hFFFF_FFFF, 64'd2, 64'h7FFF_FFFF, 34, "divuw", 1'b1);
        run_op(OP_REMU, 1'b1, 64'h1234_5678_0000_0009, 64'hABCD_0000_0000_0000, 64'd9, 2, "remuw_zero", 1'b1);

        // Backpressure: response held for ten cycles while a second request waits.
        resp_ready = 1'b0;
        run_op(OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66, "bp", 1'b0);
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = OP_MUL; req_word = 1'b0; req_a = 64'd6; req_b = 64'd7;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_stable_data", resp_data, 64'd14);
            check("bp_valid_held", {63'd0, resp_valid}, 64'd1);
            check("bp_req_ready", {63'd0, req_ready}, 64'd0);
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_idle_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1 req_valid = 1'b0;
        wait_resp("b2b_mul", 66, 64'd42);
        @(negedge clk);
        check("b2b_idle_after", {63'd0, busy}, 64'd0);

        // Flush in IDLE with a pending request: nothing is accepted.
        @(posedge clk); #1;
        flush = 1'b1; req_valid = 1'b1; req_op = OP_MUL; req_a = 64'd1; req_b = 64'd1;
        @(negedge clk);
        check("flush_idle_ready", {63'd0, req_ready}, 64'd0);
        @(posedge clk); #1 flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("flush_idle_busy", {63'd0, busy}, 64'd0);

        // Flush after 20 divide iterations discards the operation.
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = OP_DIV; req_word = 1'b0; req_a = 64'd1000; req_b = 64'd7;
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("flush_busy_before", {63'd0, busy}, 64'd1);
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy_after", {63'd0, busy}, 64'd0);
        check("flush_resp_valid", {63'd0, resp_valid}, 64'd0);
        repeat (70) @(negedge clk);
        run_op(OP_MUL, 1'b0, 64'd3, 64'd4, 64'd12, 66, "mul_after_flush", 1'b1);

        // Async reset pulse in the middle of a divide.
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = OP_DIV; req_word = 1'b0; req_a = -64'sd1000; req_b = 64'd3;
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_resp_data", resp_data, 64'd0);
        check("arst_req_ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b1;
        run_op(OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66, "divu_after_reset", 1'b1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
